// File: rtl/sram_bus_arbiter.sv
// Two-to-one SRAM-like bus arbiter: data port has priority, one transaction
// outstanding, starvation counter forces an inst grant after STARVE_LIMIT.
module sram_bus_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    input  logic        inst_uncached,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        data_uncached,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_uncached,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {INST, DATA} port_t;

    state_t        state;
    port_t         owner;
    port_t         lock_owner;
    logic          lock_valid;
    logic [CW-1:0] starve_cnt;

    port_t gnt;
    logic  gnt_valid;
    logic  cnt_full;
    logic  starved;
    logic  sel_inst;
    logic  accept;
    logic  resp;

    assign cnt_full = (starve_cnt == CW'(STARVE_LIMIT));
    assign starved  = inst_req && cnt_full;

    always_comb begin
        gnt       = DATA;
        gnt_valid = 1'b1;
        if (lock_valid)
            gnt = lock_owner;
        else if (data_req && !starved)
            gnt = DATA;
        else if (inst_req)
            gnt = INST;
        else
            gnt_valid = 1'b0;
    end

    assign sel_inst = gnt_valid && (gnt == INST);

    // Request path is transparent only while no transaction is outstanding.
    assign m_req = (state == IDLE) && gnt_valid &&
                   (sel_inst ? inst_req : data_req);

    assign m_wr       = sel_inst ? inst_wr       : data_wr;
    assign m_size     = sel_inst ? inst_size     : data_size;
    assign m_addr     = sel_inst ? inst_addr     : data_addr;
    assign m_wdata    = sel_inst ? inst_wdata    : data_wdata;
    assign m_uncached = sel_inst ? inst_uncached : data_uncached;

    assign accept       = m_req && m_addr_ok;
    assign inst_addr_ok = accept && sel_inst;
    assign data_addr_ok = accept && !sel_inst;

    assign resp         = (state == BUSY) && m_data_ok;
    assign inst_data_ok = resp && (owner == INST);
    assign data_data_ok = resp && (owner == DATA);
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= INST;
            lock_valid <= 1'b0;
            lock_owner <= INST;
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                state      <= BUSY;
                owner      <= gnt;
                lock_valid <= 1'b0;
                if (gnt == INST || !inst_req)
                    starve_cnt <= '0;
                else if (!cnt_full)
                    starve_cnt <= starve_cnt + CW'(1);
            end else if (m_req) begin
                // Hold the source stable until the downstream takes it.
                lock_valid <= 1'b1;
                lock_owner <= gnt;
            end
        end else if (m_data_ok) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Randomized self-checking bench for sram_bus_arbiter against a
// transaction-level reference model of the grant/starvation rules.
module tb_sram_bus_arbiter;

    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, inst_uncached;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr, data_uncached;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        m_req, m_wr, m_uncached;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;

    sram_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_uncached(inst_uncached),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_uncached(data_uncached),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_uncached(m_uncached),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit        pend;
        bit        wr;
        bit [1:0]  size;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit        unc;
    } req_t;

    int   n_checks = 0;
    int   n_fails  = 0;
    req_t ip, dp;
    // model: port ids 0 = none, 1 = inst, 2 = data
    bit   busy;
    int   owner;
    bit   lock;
    int   lock_port;
    int   starve;
    int   n_inst_gnt, n_data_gnt;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic req_t new_req();
        req_t r;
        r.pend  = 1'b1;
        r.wr    = 1'($urandom_range(1));
        r.size  = 2'($urandom_range(2));
        r.addr  = $urandom;
        r.wdata = $urandom;
        r.unc   = 1'($urandom_range(1));
        return r;
    endfunction

    task automatic drive();
        inst_req      = ip.pend;
        inst_wr       = ip.wr;
        inst_size     = ip.size;
        inst_addr     = ip.addr;
        inst_wdata    = ip.wdata;
        inst_uncached = ip.unc;
        data_req      = dp.pend;
        data_wr       = dp.wr;
        data_size     = dp.size;
        data_addr     = dp.addr;
        data_wdata    = dp.wdata;
        data_uncached = dp.unc;
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input int p_i, input int p_d, input int p_aok,
                        input int p_dok, input bit do_rst);
        int   g;
        bit   exp_req;
        req_t gr;
        if (!ip.pend && $urandom_range(99) < p_i) ip = new_req();
        if (!dp.pend && $urandom_range(99) < p_d) dp = new_req();
        drive();
        m_addr_ok = ($urandom_range(99) < p_aok);
        m_data_ok = ($urandom_range(99) < p_dok);
        m_rdata   = $urandom;
        if (do_rst) begin
            m_data_ok = 1'b1;
            rst = 1'b1;
            #1;
            busy   = 1'b0;
            lock   = 1'b0;
            starve = 0;
            check("rst_m_req", 32'(m_req), 32'(ip.pend | dp.pend));
            check("rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
            check("rst_data_data_ok", 32'(data_data_ok), 32'd0);
            #1 rst = 1'b0;
        end
        @(negedge clk);
        g = 0;
        if (!busy) begin
            if (lock)
                g = lock_port;
            else if (dp.pend && !(ip.pend && starve == LIMIT))
                g = 2;
            else if (ip.pend)
                g = 1;
        end
        exp_req = (g != 0);
        gr = (g == 1) ? ip : dp;
        check("m_req", 32'(m_req), 32'(exp_req));
        check("inst_addr_ok", 32'(inst_addr_ok),
              32'(exp_req && g == 1 && m_addr_ok));
        check("data_addr_ok", 32'(data_addr_ok),
              32'(exp_req && g == 2 && m_addr_ok));
        check("inst_data_ok", 32'(inst_data_ok),
              32'(busy && m_data_ok && owner == 1));
        check("data_data_ok", 32'(data_data_ok),
              32'(busy && m_data_ok && owner == 2));
        check("inst_rdata", inst_rdata, m_rdata);
        check("data_rdata", data_rdata, m_rdata);
        if (!busy) begin
            check("m_wr", 32'(m_wr), 32'(gr.wr));
            check("m_size", 32'(m_size), 32'(gr.size));
            check("m_addr", m_addr, gr.addr);
            check("m_wdata", m_wdata, gr.wdata);
            check("m_uncached", 32'(m_uncached), 32'(gr.unc));
        end
        if (busy) begin
            if (m_data_ok) busy = 1'b0;
        end else if (exp_req) begin
            if (m_addr_ok) begin
                busy  = 1'b1;
                owner = g;
                lock  = 1'b0;
                if (g == 2) begin
                    starve = ip.pend ? ((starve < LIMIT) ? starve + 1 : LIMIT)
                                     : 0;
                    n_data_gnt++;
                    dp.pend = 1'b0;
                end else begin
                    starve = 0;
                    n_inst_gnt++;
                    ip.pend = 1'b0;
                end
            end else begin
                lock      = 1'b1;
                lock_port = g;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        ip = '0;
        dp = '0;
        busy = 1'b0; owner = 1; lock = 1'b0; lock_port = 0; starve = 0;
        rst = 1'b1;
        drive();
        m_addr_ok = 1'b1;
        m_data_ok = 1'b1;
        m_rdata   = 32'hDEADBEEF;
        #2;
        check("reset_m_req_idle", 32'(m_req), 32'd0);
        check("reset_inst_data_ok", 32'(inst_data_ok), 32'd0);
        check("reset_data_data_ok", 32'(data_data_ok), 32'd0);
        ip = '{1'b1, 1'b0, 2'd2, 32'h1FC0_0100, 32'h0, 1'b1};
        drive();
        #1;
        check("reset_m_req_transparent", 32'(m_req), 32'd1);
        check("reset_m_addr", m_addr, 32'h1FC0_0100);
        ip = '0;
        drive();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Both ports saturate, downstream always ready: 8 data, 1 inst.
        n_inst_gnt = 0;
        n_data_gnt = 0;
        for (int i = 0; i < 54; i++) step(100, 100, 100, 100, 1'b0);
        check("starve_inst_grants", 32'(n_inst_gnt), 32'd3);
        check("starve_data_grants", 32'(n_data_gnt), 32'd24);
        for (int i = 0; i < 4; i++) step(0, 0, 100, 100, 1'b0);

        // Byte write pass-through on the data port.
        dp = '{1'b1, 1'b1, 2'd0, 32'h8000_0003, 32'h0000_00AA, 1'b0};
        for (int i = 0; i < 4; i++) step(0, 0, 100, 100, 1'b0);

        for (int i = 0; i < 3000; i++) step(50, 60, 50, 40, 1'b0);
        for (int i = 0; i < 2000; i++) step(70, 70, 15, 50, 1'b0);
        for (int i = 0; i < 2000; i++)
            step(60, 60, 60, 50, ($urandom_range(49) == 0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
